// File: rtl/song_pkg.sv
// Shared types and entry-word field positions for the song reader.
package song_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      PLAY   = 3'd3,
      DONE   = 3'd4
   } state_t;

   // Entry word: {END, DUR[6:0], rsvd, MASK[6:0]}
   localparam int END_BIT  = 15;
   localparam int DUR_MSB  = 14;
   localparam int DUR_LSB  = 8;
   localparam int MASK_MSB = 6;
   localparam int MASK_LSB = 0;

   localparam int KEY_W  = 16;
   localparam int DUR_W  = DUR_MSB - DUR_LSB + 1;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider that produces one-cycle duration ticks while enabled.
module tick_prescaler #(
   parameter int TICK_DIV = 2_500_000
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] r_cnt;

   // Count 0..TICK_DIV-1 and wrap; clear parks the count at zero.
   always_ff @(posedge clock) begin
      if (reset || clear)    r_cnt <= '0;
      else if (r_cnt == LAST) r_cnt <= '0;
      else                   r_cnt <= r_cnt + CNT_W'(1);
   end

   assign tick = (r_cnt == LAST) && !clear;

endmodule

// File: rtl/song_reader.sv
// Note sequencer: walks a note table on RAM port B and drives the key mask.
module song_reader
   import song_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR = 16'h0100,
   parameter int          MAX_LEN   = 256,
   parameter int          TICK_DIV  = 2_500_000,
   parameter int          RD_LAT    = 2,
   parameter int          LOOP      = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic [15:0] data_b,
   output logic [15:0] Address_B,
   output logic [15:0] Key_Pressed,
   output logic        playing,
   output logic        song_done
);

   localparam int IDX_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int WAIT_W = $clog2(RD_LAT + 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(MAX_LEN - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LAT - 1);

   state_t              r_state, w_next;
   logic [IDX_W-1:0]    r_idx, w_idx, w_idx_inc;
   logic [WAIT_W-1:0]   r_wait, w_wait;
   logic [15:0]         r_entry, w_entry;
   logic [DUR_W-1:0]    r_dur, w_dur;
   logic [15:0]         r_addr, w_addr;
   logic [KEY_W-1:0]    r_key, w_key;
   logic                r_playing, r_done;
   logic                w_tick, w_presc_clr;
   logic                w_unused_rsvd;

   // Reserved entry bit carries no meaning.
   assign w_unused_rsvd = r_entry[7];

   function automatic logic [15:0] addr_of(input logic [IDX_W-1:0] i);
      return 16'(BASE_ADDR + 16'(i));
   endfunction

   // Prescaler only runs in PLAY, so every note starts on a fresh tick phase.
   assign w_presc_clr = (r_state != PLAY);

   tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
      .clock (clock),
      .reset (reset),
      .clear (w_presc_clr),
      .tick  (w_tick)
   );

   assign w_idx_inc = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);

   // Next-state and next-register values; enable low overrides everything.
   always_comb begin
      w_next  = r_state;
      w_idx   = r_idx;
      w_wait  = r_wait;
      w_entry = r_entry;
      w_dur   = r_dur;
      w_addr  = r_addr;
      w_key   = r_key;
      case (r_state)
         IDLE: begin
            w_idx  = '0;
            w_key  = '0;
            w_addr = addr_of('0);
            if (enable) begin
               w_wait = '0;
               w_next = FETCH;
            end
         end
         FETCH: begin
            if (r_wait == WAIT_LAST) begin
               w_entry = data_b;
               w_next  = DECODE;
            end else begin
               w_wait = r_wait + WAIT_W'(1);
            end
         end
         DECODE: begin
            if (r_entry[END_BIT]) begin
               if (LOOP != 0) begin
                  w_idx  = '0;
                  w_addr = addr_of('0);
                  w_wait = '0;
                  w_next = FETCH;
               end else begin
                  w_key  = '0;
                  w_next = DONE;
               end
            end else if (r_entry[DUR_MSB:DUR_LSB] == '0) begin
               w_idx  = w_idx_inc;
               w_addr = addr_of(w_idx_inc);
               w_wait = '0;
               w_next = FETCH;
            end else begin
               w_key  = KEY_W'(r_entry[MASK_MSB:MASK_LSB]);
               w_dur  = r_entry[DUR_MSB:DUR_LSB];
               w_next = PLAY;
            end
         end
         PLAY: begin
            // Key mask is left as-is so the next note follows without a gap.
            if (w_tick) begin
               if (r_dur == DUR_W'(1)) begin
                  w_idx  = w_idx_inc;
                  w_addr = addr_of(w_idx_inc);
                  w_wait = '0;
                  w_next = FETCH;
               end else begin
                  w_dur = r_dur - DUR_W'(1);
               end
            end
         end
         DONE: begin
            w_key = '0;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
      if (!enable) begin
         w_next = IDLE;
         w_key  = '0;
         w_idx  = '0;
         w_addr = addr_of('0);
      end
   end

   // State and registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= IDLE;
         r_idx     <= '0;
         r_wait    <= '0;
         r_entry   <= '0;
         r_dur     <= '0;
         r_addr    <= BASE_ADDR;
         r_key     <= '0;
         r_playing <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_idx     <= w_idx;
         r_wait    <= w_wait;
         r_entry   <= w_entry;
         r_dur     <= w_dur;
         r_addr    <= w_addr;
         r_key     <= w_key;
         r_playing <= (w_next == PLAY);
         r_done    <= (w_next == DONE);
      end
   end

   assign Address_B   = r_addr;
   assign Key_Pressed = r_key;
   assign playing     = r_playing;
   assign song_done   = r_done;

endmodule

// File: tb/tb_song_reader.sv
// Directed bench for song_reader: cycle table on a LOOP=0 instance plus
// short sequences for looping, skip entries and index wrap.
module tb_song_reader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // DUT0: LOOP=0, DUT1: LOOP=1, DUT2: LOOP=1 with MAX_LEN=4
   logic        rst0, rst1, rst2, en0, en1, en2;
   logic [15:0] db0, db1, db2, a0, a1, a2, k0, k1, k2;
   logic        p0, p1, p2, d0, d1, d2;
   logic [15:0] mem0[4], mem1[4], mem2[4];
   logic [15:0] ad0, ad1, ad2;

   song_reader #(.BASE_ADDR(16'h0100), .MAX_LEN(256), .TICK_DIV(4), .RD_LAT(2), .LOOP(0)) u0 (
      .clock(clk), .reset(rst0), .enable(en0), .data_b(db0),
      .Address_B(a0), .Key_Pressed(k0), .playing(p0), .song_done(d0));
   song_reader #(.BASE_ADDR(16'h0100), .MAX_LEN(256), .TICK_DIV(4), .RD_LAT(2), .LOOP(1)) u1 (
      .clock(clk), .reset(rst1), .enable(en1), .data_b(db1),
      .Address_B(a1), .Key_Pressed(k1), .playing(p1), .song_done(d1));
   song_reader #(.BASE_ADDR(16'h0100), .MAX_LEN(4), .TICK_DIV(4), .RD_LAT(2), .LOOP(1)) u2 (
      .clock(clk), .reset(rst2), .enable(en2), .data_b(db2),
      .Address_B(a2), .Key_Pressed(k2), .playing(p2), .song_done(d2));

   // RAM model: address registered once, data ready by the end of the
   // second cycle after Address_B changes.
   always @(posedge clk) begin
      ad0 <= a0;
      ad1 <= a1;
      ad2 <= a2;
   end
   always_comb begin
      db0 = 16'hFFFF;
      db1 = 16'hFFFF;
      db2 = 16'hFFFF;
      if (ad0 >= 16'h0100 && ad0 < 16'h0104) db0 = mem0[ad0[1:0]];
      if (ad1 >= 16'h0100 && ad1 < 16'h0104) db1 = mem1[ad1[1:0]];
      if (ad2 >= 16'h0100 && ad2 < 16'h0104) db2 = mem2[ad2[1:0]];
   end

   typedef struct {
      logic        rst;
      logic        en;
      logic [15:0] a;
      logic [15:0] k;
      logic        p;
      logic        d;
   } vec_t;

   vec_t tv[$];
   int   errs = 0;
   int   checks = 0;

   task automatic add(input int n, input logic r, input logic e, input logic [15:0] a,
                      input logic [15:0] k, input logic p, input logic d);
      for (int i = 0; i < n; i++) tv.push_back('{r, e, a, k, p, d});
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   logic [15:0] first_nz, chg[$];
   int          nz_cyc, saw3, done_seen, fails_t;
   logic [15:0] last_a;

   initial begin
      rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
      en0 = 1'b0;  en1 = 1'b0;  en2 = 1'b0;
      mem0[0] = 16'h0205; mem0[1] = 16'h0112; mem0[2] = 16'h8000; mem0[3] = 16'h8000;
      mem1[0] = 16'h0205; mem1[1] = 16'h0112; mem1[2] = 16'h8000; mem1[3] = 16'h8000;
      mem2[0] = 16'h0101; mem2[1] = 16'h0102; mem2[2] = 16'h0104; mem2[3] = 16'h0108;

      // rows: count, reset, enable -> Address_B, Key_Pressed, playing, song_done
      add(1, 1, 0, 16'h0100, 16'h0000, 0, 0);   // reset
      add(3, 0, 1, 16'h0100, 16'h0000, 0, 0);   // FETCH x2, DECODE
      add(8, 0, 1, 16'h0100, 16'h0005, 1, 0);   // entry 0: DUR 2 * 4
      add(3, 0, 1, 16'h0101, 16'h0005, 0, 0);   // mask held through fetch
      add(4, 0, 1, 16'h0101, 16'h0012, 1, 0);   // entry 1: DUR 1 * 4
      add(3, 0, 1, 16'h0102, 16'h0012, 0, 0);
      add(2, 0, 1, 16'h0102, 16'h0000, 0, 1);   // END, LOOP=0 -> DONE
      add(1, 0, 0, 16'h0100, 16'h0000, 0, 0);   // DONE -> IDLE
      add(3, 0, 1, 16'h0100, 16'h0000, 0, 0);   // replay
      add(8, 0, 1, 16'h0100, 16'h0005, 1, 0);
      add(3, 0, 1, 16'h0101, 16'h0005, 0, 0);
      add(1, 0, 1, 16'h0101, 16'h0012, 1, 0);   // PLAY of entry 1
      add(1, 0, 0, 16'h0100, 16'h0000, 0, 0);   // abort mid-PLAY
      add(3, 0, 1, 16'h0100, 16'h0000, 0, 0);   // restart from entry 0
      add(1, 0, 1, 16'h0100, 16'h0005, 1, 0);
      add(1, 0, 0, 16'h0100, 16'h0000, 0, 0);
      add(1, 0, 1, 16'h0100, 16'h0000, 0, 0);   // FETCH
      add(1, 1, 1, 16'h0100, 16'h0000, 0, 0);   // reset in FETCH
      add(3, 0, 1, 16'h0100, 16'h0000, 0, 0);   // FETCH begins one cycle later
      add(1, 0, 1, 16'h0100, 16'h0005, 1, 0);
      add(1, 0, 0, 16'h0100, 16'h0000, 0, 0);
      add(3, 0, 1, 16'h0100, 16'h0000, 0, 0);   // up to DECODE
      add(2, 0, 0, 16'h0100, 16'h0000, 0, 0);   // abort beats DECODE

      for (int i = 0; i < tv.size(); i++) begin
         @(negedge clk);
         rst0 = tv[i].rst;
         en0  = tv[i].en;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d {addr,key,play,done}", i),
             64'({a0, k0, p0, d0}), 64'({tv[i].a, tv[i].k, tv[i].p, tv[i].d}));
      end

      // Skip a DUR=0 entry (DUT0 idle here).
      mem0[0] = 16'h0003; mem0[1] = 16'h0140; mem0[2] = 16'h8000;
      first_nz = 16'h0000; nz_cyc = 0; saw3 = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         en0 = 1'b1;
         @(posedge clk);
         #1;
         if (k0 == 16'h0003) saw3++;
         if (k0 != 16'h0000 && first_nz == 16'h0000) begin
            first_nz = k0;
            nz_cyc = c;
         end
         if (c == 4) chk("skip addr after DUR0", 64'(a0), 64'h0101);
      end
      chk("skip first key", 64'(first_nz), 64'h0040);
      chk("skip first key cycle", 64'(nz_cyc), 64'd7);
      chk("skip 0003 never shown", 64'(saw3), 64'd0);
      @(negedge clk);
      en0 = 1'b0;

      // LOOP=1 replays entry 0 after END, never DONE.
      @(negedge clk);
      rst1 = 1'b1;
      @(posedge clk);
      #1;
      chk("loop reset state", 64'({a1, k1, p1, d1}), 64'({16'h0100, 16'h0000, 1'b0, 1'b0}));
      done_seen = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         rst1 = 1'b0;
         en1  = 1'b1;
         @(posedge clk);
         #1;
         if (d1) done_seen++;
         if (c == 22) chk("loop restart addr/key", 64'({a1, k1, p1}), 64'({16'h0100, 16'h0012, 1'b0}));
         if (c == 25) chk("loop replay entry 0", 64'({a1, k1, p1}), 64'({16'h0100, 16'h0005, 1'b1}));
      end
      chk("loop song_done never", 64'(done_seen), 64'd0);

      // MAX_LEN=4: index wraps 3 -> 0.
      @(negedge clk);
      rst2 = 1'b1;
      @(posedge clk);
      #1;
      last_a = a2;
      chk("wrap reset addr", 64'(a2), 64'h0100);
      for (int c = 1; c <= 80 && chg.size() < 5; c++) begin
         @(negedge clk);
         rst2 = 1'b0;
         en2  = 1'b1;
         @(posedge clk);
         #1;
         if (a2 != last_a) begin
            chg.push_back(a2);
            last_a = a2;
         end
      end
      chk("wrap change count", 64'(chg.size()), 64'd5);
      fails_t = 0;
      if (chg.size() == 5) begin
         logic [15:0] exp_seq[5];
         exp_seq = '{16'h0101, 16'h0102, 16'h0103, 16'h0100, 16'h0101};
         for (int i = 0; i < 5; i++)
            chk($sformatf("wrap addr[%0d]", i), 64'(chg[i]), 64'(exp_seq[i]));
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
